// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, hands the returned word to decode with a valid/ready handshake, and
// follows control-flow redirects from next-PC logic. A redirect arriving while
// a request is outstanding moves to DRAIN, which completes the stale request
// and throws its data away before fetching from the new target.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] redirect_tgt;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Next-state and datapath update; redirect is checked first in every state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d = redirect_tgt;
        end
      end

      FETCH: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          if (!imem_ack) begin
            // The request on the bus is still live: remember its address so
            // DRAIN can keep it stable until the memory answers.
            req_addr_d = pc_q;
            state_d    = DRAIN;
          end
          // Ack in the same cycle: the word belongs to the old path, drop it
          // and start fetching the target right away.
        end else if (imem_ack) begin
          if_inst_d = imem_rdata;
          if_pc_d   = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = OUT;
        end else begin
          req_addr_d = pc_q;
        end
      end

      OUT: begin
        if (redirect) begin
          // Squash the held instruction; it is never counted.
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (if_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so that
  // every port is driven straight from a flop.
  always_comb begin
    imem_req_d  = (state_d == FETCH) || (state_d == DRAIN);
    imem_addr_d = (state_d == DRAIN) ? req_addr_d : pc_d;
    if_valid_d  = (state_d == OUT);
  end

  // State, datapath and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      if_pc_q     <= 32'h0000_0000;
      if_inst_q   <= NOP_INST;
      fetch_cnt_q <= 32'h0000_0000;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      fetch_cnt_q <= fetch_cnt_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] fetch_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .fetch_cnt  (fetch_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[14];

  // Reference model: a fetch is either not started, in flight (possibly
  // doomed by a redirect), or completed and waiting at decode.
  logic        m_idle, m_live, m_doomed, m_held;
  logic [31:0] m_pc, m_bus_addr, m_ipc, m_inst, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] rdata, input logic rdy);
    rst_n       = r;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = rdata;
    if_ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_live = 1'b0; m_doomed = 1'b0; m_held = 1'b0;
    m_pc = 32'h0; m_bus_addr = 32'h0; m_ipc = 32'h0; m_inst = 32'h13; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc,
                            input logic ack, input logic [31:0] rdata, input logic rdy);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (!r) begin
      model_reset();
    end else if (m_idle) begin
      m_idle = 1'b0;
      m_live = 1'b1;
      if (rd) m_pc = tgt;
      m_bus_addr = m_pc;
    end else if (m_held) begin
      if (rd || rdy) begin
        if (!rd) m_cnt = m_cnt + 1;
        if (rd) m_pc = tgt;
        m_held = 1'b0;
        m_live = 1'b1;
        m_bus_addr = m_pc;
      end
    end else if (m_live && !m_doomed) begin
      if (ack && !rd) begin
        m_inst = rdata;
        m_ipc  = m_pc;
        m_pc   = m_pc + 4;
        m_live = 1'b0;
        m_held = 1'b1;
      end else if (rd) begin
        // Without ack the old address stays on the bus until answered.
        m_doomed = !ack;
        m_pc = tgt;
        if (ack) m_bus_addr = m_pc;
      end
    end else begin
      if (rd) m_pc = tgt;
      if (ack) begin
        m_doomed = 1'b0;
        m_bus_addr = m_pc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;

    //          rst  rd  rpc            ack  rdata          rdy   req  addr           vld  pc             inst           cnt
    vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h13,       32'd0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h13,       32'd0};
    vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h13,       32'd0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h00500093, 32'd0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        32'd1};
    vt[5]  = '{1'b1, 1'b1, 32'h102,      1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        32'd1};
    vt[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1'b0, 32'h0,        32'h0,        32'd1};
    vt[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        32'd1};
    vt[8]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h11111111, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        32'd1};
    vt[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h22222222, 32'd1};
    vt[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        32'd2};
    vt[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h33333333, 32'd2};
    vt[12] = '{1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        32'h0,        32'd2};
    vt[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44444444, 1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      32'h44444444, 32'd2};

    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      step(vt[i].rst_n, vt[i].rd, vt[i].rpc, vt[i].ack, vt[i].rdata, vt[i].rdy);
      chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vt[i].e_valid});
      if (vt[i].e_valid || !vt[i].rst_n) begin
        chk($sformatf("vec%0d if_pc", i), if_pc, vt[i].e_pc);
        chk($sformatf("vec%0d if_inst", i), if_inst, vt[i].e_inst);
      end
      chk($sformatf("vec%0d fetch_cnt", i), fetch_cnt, vt[i].e_cnt);
    end

    // Wait-state ack and decode stall, starting from OUT holding 0x200.
    step(1, 0, 0, 0, 0, 1);
    chk("stall req0", {31'b0, imem_req}, 32'd1);
    chk("stall addr0", imem_addr, 32'h204);
    chk("stall cnt0", fetch_cnt, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 32'hBAD0BAD0, 0);
      chk($sformatf("wait%0d req", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("wait%0d addr", i), imem_addr, 32'h204);
      chk($sformatf("wait%0d valid", i), {31'b0, if_valid}, 32'd0);
    end
    step(1, 0, 0, 1, 32'h55555555, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d valid", i), {31'b0, if_valid}, 32'd1);
      chk($sformatf("hold%0d req", i), {31'b0, imem_req}, 32'd0);
      chk($sformatf("hold%0d pc", i), if_pc, 32'h204);
      chk($sformatf("hold%0d inst", i), if_inst, 32'h55555555);
      if (i < 4) step(1, 0, 0, 1, 32'h0, 0);
    end
    step(1, 0, 0, 0, 0, 1);
    chk("release valid", {31'b0, if_valid}, 32'd0);
    chk("release addr", imem_addr, 32'h208);
    chk("release cnt", fetch_cnt, 32'd4);

    // Reset pulse while draining; the late ack must not be used.
    step(1, 1, 32'h300, 0, 0, 0);
    chk("drain req", {31'b0, imem_req}, 32'd1);
    chk("drain addr", imem_addr, 32'h208);
    step(0, 0, 0, 1, 32'h77777777, 1);
    chk("rst req", {31'b0, imem_req}, 32'd0);
    chk("rst valid", {31'b0, if_valid}, 32'd0);
    chk("rst cnt", fetch_cnt, 32'd0);
    chk("rst inst", if_inst, 32'h13);
    step(1, 0, 0, 1, 32'h88888888, 1);
    chk("restart req", {31'b0, imem_req}, 32'd1);
    chk("restart addr", imem_addr, 32'h0);
    chk("restart valid", {31'b0, if_valid}, 32'd0);
    step(1, 0, 0, 1, 32'h66666666, 0);
    chk("restart out valid", {31'b0, if_valid}, 32'd1);
    chk("restart out pc", if_pc, 32'h0);
    chk("restart out inst", if_inst, 32'h66666666);
    chk("restart out cnt", fetch_cnt, 32'd0);

    // Randomized traffic against the model.
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, ack, rdy;
      logic [31:0] rpc, rdata;
      r     = ($urandom_range(0, 99) != 0);
      rd    = ($urandom_range(0, 7) == 0);
      rpc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom;
      ack   = ($urandom_range(0, 9) < 4);
      rdata = $urandom;
      rdy   = ($urandom_range(0, 9) < 7);
      step(r, rd, rpc, ack, rdata, rdy);
      model_step(r, rd, rpc, ack, rdata, rdy);
      chk($sformatf("rnd%0d imem_req", i), {31'b0, imem_req}, {31'b0, m_live});
      if (m_live) chk($sformatf("rnd%0d imem_addr", i), imem_addr, m_bus_addr);
      chk($sformatf("rnd%0d if_valid", i), {31'b0, if_valid}, {31'b0, m_held});
      chk($sformatf("rnd%0d if_pc", i), if_pc, m_ipc);
      chk($sformatf("rnd%0d if_inst", i), if_inst, m_inst);
      chk($sformatf("rnd%0d fetch_cnt", i), fetch_cnt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
